// File: rtl/ram_arbiter_if.sv
// ram_arbiter_if: request/access/RAM bundle shared by the three requesters, the arbiter and the RAM.
// Signals: req/acc/wr (3 each), packed x_in/y_in (3x3 bit), wdata (3xCOL_W), grant, RAM port, read return, err.
// master = requesters + RAM model side, slave = arbiter side.
interface ram_arbiter_if #(
    parameter int COL_W  = 3,
    parameter int ADDR_W = 6
);
    logic [2:0]         req;
    logic [2:0]         acc;
    logic [2:0]         wr;
    logic [8:0]         x_in;
    logic [8:0]         y_in;
    logic [3*COL_W-1:0] wdata;
    logic [2:0]         grant;
    logic [ADDR_W-1:0]  ram_addr;
    logic               ram_wren;
    logic [COL_W-1:0]   ram_data;
    logic [COL_W-1:0]   ram_q;
    logic               rvalid;
    logic [COL_W-1:0]   rdata;
    logic [1:0]         rid;
    logic               err;

    modport master (
        output req, acc, wr, x_in, y_in, wdata, ram_q,
        input  grant, ram_addr, ram_wren, ram_data, rvalid, rdata, rid, err
    );

    modport slave (
        input  req, acc, wr, x_in, y_in, wdata, ram_q,
        output grant, ram_addr, ram_wren, ram_data, rvalid, rdata, rid, err
    );
endinterface

// File: rtl/ram_arbiter.sv
// ram_arbiter: grants one of three requesters (0=scanner, 1=mapper, 2=cleaner) a single-port pixel RAM.
// Latency: grant registered (1 edge after req); address/write decode combinational; rvalid/err 1 cycle after access.
// Ports: clk, resetn (sync, active-low), bus (ram_arbiter_if.slave). Macro RAM_ARB_RR_EN selects round-robin,
// otherwise fixed priority cleaner > mapper > scanner. The owner keeps the bus until it drops its own req.
module ram_arbiter #(
    parameter int IMG_W = 6,
    parameter int IMG_H = 6,
    parameter int COL_W = 3
) (
    input  logic         clk,
    input  logic         resetn,
    ram_arbiter_if.slave bus
);
    localparam int ADDR_W = $clog2(IMG_W * IMG_H);

    typedef enum logic {S_IDLE = 1'b0, S_OWNED = 1'b1} state_t;

    state_t            state_q;
    logic [2:0]        grant_q;
    logic [1:0]        owner_c;
    logic [2:0]        own_x_c;
    logic [2:0]        own_y_c;
    logic [COL_W-1:0]  own_wdata_c;
    logic              own_req_c;
    logic              own_acc_c;
    logic              own_wr_c;
    logic              in_range_c;
    logic [ADDR_W-1:0] addr_c;
    logic [2:0]        win_c;

    logic              rvalid_q, rvalid_d;
    logic [1:0]        rid_q, rid_d;
    logic              err_q, err_d;

    // Owner index from the one-hot grant; 0 when idle, but every owner-qualified
    // strobe below is masked by grant_q so the idle value never matters.
    always_comb begin
        owner_c = 2'd0;
        if (grant_q[1]) owner_c = 2'd1;
        if (grant_q[2]) owner_c = 2'd2;
    end

    always_comb begin
        own_x_c     = bus.x_in[2:0];
        own_y_c     = bus.y_in[2:0];
        own_wdata_c = bus.wdata[COL_W-1:0];
        case (owner_c)
            2'd1: begin
                own_x_c     = bus.x_in[5:3];
                own_y_c     = bus.y_in[5:3];
                own_wdata_c = bus.wdata[2*COL_W-1:COL_W];
            end
            2'd2: begin
                own_x_c     = bus.x_in[8:6];
                own_y_c     = bus.y_in[8:6];
                own_wdata_c = bus.wdata[3*COL_W-1:2*COL_W];
            end
            default: ;
        endcase
    end

    // Non-owner strobes vanish here: only the granted bit survives the mask.
    assign own_req_c  = |(bus.req & grant_q);
    assign own_acc_c  = |(bus.acc & grant_q);
    assign own_wr_c   = |(bus.wr  & grant_q);
    assign in_range_c = (int'(own_x_c) < IMG_W) && (int'(own_y_c) < IMG_H);
    assign addr_c     = ADDR_W'(own_y_c) * ADDR_W'(IMG_W) + ADDR_W'(own_x_c);

    assign bus.ram_addr = (grant_q == 3'b000) ? '0 : addr_c;
    assign bus.ram_data = own_wdata_c;
    assign bus.ram_wren = own_acc_c & own_wr_c & in_range_c;

`ifdef RAM_ARB_RR_EN
    // One-hot marker of the requester the next search starts from.
    logic [2:0] rr_ptr_q, rr_ptr_d;
    logic       new_grant_c;

    always_comb begin
        case (rr_ptr_q)
            3'b010:  win_c = bus.req[1] ? 3'b010 : bus.req[2] ? 3'b100 : bus.req[0] ? 3'b001 : 3'b000;
            3'b100:  win_c = bus.req[2] ? 3'b100 : bus.req[0] ? 3'b001 : bus.req[1] ? 3'b010 : 3'b000;
            default: win_c = bus.req[0] ? 3'b001 : bus.req[1] ? 3'b010 : bus.req[2] ? 3'b100 : 3'b000;
        endcase
    end

    // A new grant is issued whenever the bus is free (idle or owner released) and someone asks.
    assign new_grant_c = (|bus.req) & ((grant_q == 3'b000) | ~own_req_c);
    // Next search starts just after the winner: rotate the one-hot left by one.
    assign rr_ptr_d    = new_grant_c ? {win_c[1:0], win_c[2]} : rr_ptr_q;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            rr_ptr_q <= 3'b001;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end
`else
    always_comb begin
        win_c = bus.req[2] ? 3'b100 : bus.req[1] ? 3'b010 : bus.req[0] ? 3'b001 : 3'b000;
    end
`endif

    // When the owner releases, the remaining req bits are arbitrated on the same
    // edge so the bus hands off with no idle cycle in between.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            grant_q <= 3'b000;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (|bus.req) begin
                        state_q <= S_OWNED;
                        grant_q <= win_c;
                    end
                end
                S_OWNED: begin
                    if (!own_req_c) begin
                        if (|bus.req) begin
                            grant_q <= win_c;
                        end else begin
                            state_q <= S_IDLE;
                            grant_q <= 3'b000;
                        end
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    grant_q <= 3'b000;
                end
            endcase
        end
    end

    assign bus.grant = grant_q;

    // Read return: the RAM answers one cycle after the address, so rid is captured
    // at access time and survives a grant change on the same edge.
    assign rvalid_d = own_acc_c & ~own_wr_c & in_range_c;
    assign rid_d    = rvalid_d ? owner_c : rid_q;
    assign err_d    = own_acc_c & ~in_range_c;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            rvalid_q <= 1'b0;
            rid_q    <= 2'd0;
            err_q    <= 1'b0;
        end else begin
            rvalid_q <= rvalid_d;
            rid_q    <= rid_d;
            err_q    <= err_d;
        end
    end

    assign bus.rvalid = rvalid_q;
    assign bus.rid    = rid_q;
    assign bus.err    = err_q;
    assign bus.rdata  = bus.ram_q;
endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: directed scenarios plus a randomized run against a behavioural arbiter/RAM model.
module tb_ram_arbiter;
    logic clk = 1'b0;
    logic resetn = 1'b0;
    int   checks = 0;
    int   errors = 0;

    ram_arbiter_if #(.COL_W(3), .ADDR_W(6)) bus ();

    ram_arbiter #(.IMG_W(6), .IMG_H(6), .COL_W(3)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    // Power-on contents of the pixel RAM: value at address i.
    function automatic logic [2:0] pat(input int i);
        return 3'((3 * i + 1) % 8);
    endfunction

    // Behavioural single-port RAM, one-cycle read latency, reloads its pattern during reset.
    logic [2:0] mem [0:63];
    always @(posedge clk) begin
        if (!resetn) begin
            for (int i = 0; i < 64; i++) mem[i] <= pat(i);
        end else if (bus.ram_wren) begin
            mem[bus.ram_addr] <= bus.ram_data;
        end
        bus.ram_q <= mem[bus.ram_addr];
    end

    // Reference model state
    int         m_owner;
    int         m_rr_start;
    logic [2:0] mmem [0:63];

    function automatic int pick(input logic [2:0] r);
        int w;
        w = -1;
`ifdef RAM_ARB_RR_EN
        for (int k = 0; k < 3; k++)
            if (w < 0 && r[(m_rr_start + k) % 3]) w = (m_rr_start + k) % 3;
`else
        for (int i = 2; i >= 0; i--)
            if (w < 0 && r[i]) w = i;
`endif
        return w;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_fld(input int i, input int x, input int y, input int d);
        bus.x_in[3*i +: 3]  = 3'(x);
        bus.y_in[3*i +: 3]  = 3'(y);
        bus.wdata[3*i +: 3] = 3'(d);
    endtask

    task automatic clear_inputs();
        bus.req = 3'b000; bus.acc = 3'b000; bus.wr = 3'b000;
        bus.x_in = '0; bus.y_in = '0; bus.wdata = '0;
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        clear_inputs();
        tick();
        tick();
        resetn = 1'b1;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        bus.req = 3'b111; bus.acc = 3'b111; bus.wr = 3'b000;
        tick();
        tick();
        checks++; if (bus.grant !== 3'b000) begin errors++; $display("FAIL rst_grant: got %b expected 000", bus.grant); end
        checks++; if (bus.rvalid !== 1'b0) begin errors++; $display("FAIL rst_rvalid: got %b expected 0", bus.rvalid); end
        checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL rst_err: got %b expected 0", bus.err); end
        checks++; if (bus.rid !== 2'd0) begin errors++; $display("FAIL rst_rid: got %0d expected 0", bus.rid); end
        checks++; if (bus.ram_addr !== 6'd0) begin errors++; $display("FAIL rst_addr: got %0d expected 0", bus.ram_addr); end
        checks++; if (bus.ram_wren !== 1'b0) begin errors++; $display("FAIL rst_wren: got %b expected 0", bus.ram_wren); end
    endtask

    task automatic test_handoff();
        logic [2:0] exp_hand;
`ifdef RAM_ARB_RR_EN
        exp_hand = 3'b010;
`else
        exp_hand = 3'b100;
`endif
        do_reset();
        bus.req = 3'b001;
        tick();
        checks++; if (bus.grant !== 3'b001) begin errors++; $display("FAIL ho_first: got %b expected 001", bus.grant); end
        bus.req = 3'b111;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++; if (bus.grant !== 3'b001) begin errors++; $display("FAIL ho_hold%0d: got %b expected 001", i, bus.grant); end
        end
        bus.req = 3'b110;
        tick();
        checks++; if (bus.grant !== exp_hand) begin errors++; $display("FAIL ho_handoff: got %b expected %b", bus.grant, exp_hand); end
        bus.req = 3'b000;
        tick();
        checks++; if (bus.grant !== 3'b000) begin errors++; $display("FAIL ho_idle: got %b expected 000", bus.grant); end
    endtask

    task automatic test_read();
        do_reset();
        bus.req = 3'b001;
        tick();
        set_fld(0, 2, 3, 0);
        bus.acc = 3'b001; bus.wr = 3'b000;
        #1;
        checks++; if (bus.ram_addr !== 6'd20) begin errors++; $display("FAIL rd_addr: got %0d expected 20", bus.ram_addr); end
        checks++; if (bus.ram_wren !== 1'b0) begin errors++; $display("FAIL rd_wren: got %b expected 0", bus.ram_wren); end
        tick();
        bus.acc = 3'b000;
        checks++; if (bus.rvalid !== 1'b1) begin errors++; $display("FAIL rd_rvalid: got %b expected 1", bus.rvalid); end
        checks++; if (bus.rdata !== 3'd5) begin errors++; $display("FAIL rd_rdata: got %0d expected 5", bus.rdata); end
        checks++; if (bus.rid !== 2'd0) begin errors++; $display("FAIL rd_rid: got %0d expected 0", bus.rid); end
        tick();
        checks++; if (bus.rvalid !== 1'b0) begin errors++; $display("FAIL rd_pulse: got %b expected 0", bus.rvalid); end
    endtask

    task automatic test_write_read();
        do_reset();
        bus.req = 3'b100;
        tick();
        // Non-owners strobing write must be ignored.
        set_fld(0, 1, 1, 7); set_fld(1, 2, 2, 7);
        bus.acc = 3'b011; bus.wr = 3'b011;
        #1;
        checks++; if (bus.ram_wren !== 1'b0) begin errors++; $display("FAIL wr_nonowner: got %b expected 0", bus.ram_wren); end
        tick();
        checks++; if (bus.rvalid !== 1'b0) begin errors++; $display("FAIL wr_nonowner_rv: got %b expected 0", bus.rvalid); end
        set_fld(2, 5, 5, 0);
        bus.acc = 3'b100; bus.wr = 3'b100;
        #1;
        checks++; if (bus.ram_wren !== 1'b1) begin errors++; $display("FAIL wr_wren: got %b expected 1", bus.ram_wren); end
        checks++; if (bus.ram_addr !== 6'd35) begin errors++; $display("FAIL wr_addr: got %0d expected 35", bus.ram_addr); end
        checks++; if (bus.ram_data !== 3'd0) begin errors++; $display("FAIL wr_data: got %0d expected 0", bus.ram_data); end
        tick();
        bus.wr = 3'b000;
        tick();
        bus.acc = 3'b000;
        checks++; if (bus.rvalid !== 1'b1) begin errors++; $display("FAIL wr_rb_rvalid: got %b expected 1", bus.rvalid); end
        checks++; if (bus.rdata !== 3'd0) begin errors++; $display("FAIL wr_rb_rdata: got %0d expected 0", bus.rdata); end
        checks++; if (bus.rid !== 2'd2) begin errors++; $display("FAIL wr_rb_rid: got %0d expected 2", bus.rid); end
    endtask

    task automatic test_out_of_range();
        do_reset();
        bus.req = 3'b010;
        tick();
        set_fld(1, 6, 0, 3);
        bus.acc = 3'b010; bus.wr = 3'b010;
        #1;
        checks++; if (bus.ram_wren !== 1'b0) begin errors++; $display("FAIL oor_wren: got %b expected 0", bus.ram_wren); end
        checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL oor_err_early: got %b expected 0", bus.err); end
        tick();
        checks++; if (bus.err !== 1'b1) begin errors++; $display("FAIL oor_err: got %b expected 1", bus.err); end
        // Out-of-range read (y too large).
        set_fld(1, 0, 6, 0);
        bus.wr = 3'b000;
        tick();
        bus.acc = 3'b000;
        checks++; if (bus.rvalid !== 1'b0) begin errors++; $display("FAIL oor_rvalid: got %b expected 0", bus.rvalid); end
        checks++; if (bus.err !== 1'b1) begin errors++; $display("FAIL oor_err_rd: got %b expected 1", bus.err); end
        tick();
        checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL oor_err_pulse: got %b expected 0", bus.err); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        bus.req = 3'b011;
        tick();
        bus.req = 3'b001;
        tick();
        set_fld(0, 1, 1, 0);
        bus.acc = 3'b001;
        tick();
        checks++; if (bus.rvalid !== 1'b1 || bus.rdata !== pat(7) || bus.rid !== 2'd0) begin errors++;
            $display("FAIL b2b_0: got v=%b d=%0d id=%0d expected v=1 d=%0d id=0", bus.rvalid, bus.rdata, bus.rid, pat(7)); end
        // Scanner's last granted cycle: it reads while releasing req.
        set_fld(0, 4, 2, 0);
        bus.req = 3'b010;
        tick();
        checks++; if (bus.grant !== 3'b010) begin errors++; $display("FAIL b2b_grant: got %b expected 010", bus.grant); end
        checks++; if (bus.rvalid !== 1'b1 || bus.rdata !== pat(16) || bus.rid !== 2'd0) begin errors++;
            $display("FAIL b2b_last: got v=%b d=%0d id=%0d expected v=1 d=%0d id=0", bus.rvalid, bus.rdata, bus.rid, pat(16)); end
        set_fld(1, 0, 5, 0);
        bus.acc = 3'b010;
        tick();
        bus.acc = 3'b000;
        checks++; if (bus.rvalid !== 1'b1 || bus.rdata !== pat(30) || bus.rid !== 2'd1) begin errors++;
            $display("FAIL b2b_2: got v=%b d=%0d id=%0d expected v=1 d=%0d id=1", bus.rvalid, bus.rdata, bus.rid, pat(30)); end
        tick();
        checks++; if (bus.rvalid !== 1'b0) begin errors++; $display("FAIL b2b_end: got %b expected 0", bus.rvalid); end
    endtask

    task automatic test_policy();
        do_reset();
`ifdef RAM_ARB_RR_EN
        logic [2:0] rel [4];
        logic [2:0] seq [4];
        rel = '{3'b111, 3'b110, 3'b101, 3'b011};
        seq = '{3'b001, 3'b010, 3'b100, 3'b001};
        for (int i = 0; i < 4; i++) begin
            bus.req = rel[i];
            tick();
            checks++; if (bus.grant !== seq[i]) begin errors++; $display("FAIL pol_rr%0d: got %b expected %b", i, bus.grant, seq[i]); end
        end
`else
        bus.req = 3'b111;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++; if (bus.grant !== 3'b100) begin errors++; $display("FAIL pol_fixed%0d: got %b expected 100", i, bus.grant); end
        end
`endif
    endtask

    task automatic test_reset_midread();
        do_reset();
        bus.req = 3'b001;
        tick();
        set_fld(0, 2, 3, 0);
        bus.acc = 3'b001;
        tick();
        checks++; if (bus.rvalid !== 1'b1) begin errors++; $display("FAIL rmr_first: got %b expected 1", bus.rvalid); end
        // Second read issued in the cycle reset is asserted: must be discarded.
        resetn = 1'b0;
        tick();
        checks++; if (bus.rvalid !== 1'b0) begin errors++; $display("FAIL rmr_rvalid: got %b expected 0", bus.rvalid); end
        checks++; if (bus.grant !== 3'b000) begin errors++; $display("FAIL rmr_grant: got %b expected 000", bus.grant); end
        resetn = 1'b1;
        clear_inputs();
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (bus.rvalid !== 1'b0) begin errors++; $display("FAIL rmr_stale%0d: got %b expected 0", i, bus.rvalid); end
        end
    endtask

    task automatic test_random();
        int         xv [3];
        int         yv [3];
        int         dv [3];
        logic [2:0] r, av, wv, exp_grant, exp_rdata;
        logic       exp_rvalid, exp_err, a, w, inr;
        int         exp_rid, ad, nw;
        do_reset();
        for (int i = 0; i < 64; i++) mmem[i] = pat(i);
        m_owner = -1; m_rr_start = 0;
        exp_grant = 3'b000; exp_rvalid = 1'b0; exp_err = 1'b0; exp_rid = 0; exp_rdata = 3'd0;
        for (int c = 0; c < 600; c++) begin
            checks++; if (bus.grant !== exp_grant) begin errors++; $display("FAIL rnd_grant c=%0d: got %b expected %b", c, bus.grant, exp_grant); end
            checks++; if (bus.rvalid !== exp_rvalid) begin errors++; $display("FAIL rnd_rvalid c=%0d: got %b expected %b", c, bus.rvalid, exp_rvalid); end
            checks++; if (bus.err !== exp_err) begin errors++; $display("FAIL rnd_err c=%0d: got %b expected %b", c, bus.err, exp_err); end
            if (exp_rvalid) begin
                checks++; if (bus.rdata !== exp_rdata || int'(bus.rid) != exp_rid) begin errors++;
                    $display("FAIL rnd_rdata c=%0d: got d=%0d id=%0d expected d=%0d id=%0d", c, bus.rdata, bus.rid, exp_rdata, exp_rid); end
            end
            r = 3'($urandom);
            if (m_owner >= 0) r[m_owner] = ($urandom_range(3) != 0);
            av = 3'($urandom); wv = 3'($urandom);
            for (int i = 0; i < 3; i++) begin
                xv[i] = $urandom_range(6); yv[i] = $urandom_range(6); dv[i] = $urandom_range(7);
                set_fld(i, xv[i], yv[i], dv[i]);
            end
            bus.req = r; bus.acc = av; bus.wr = wv;
            #1;
            ad = 0; a = 1'b0; w = 1'b0; inr = 1'b0;
            if (m_owner >= 0) begin
                ad  = yv[m_owner] * 6 + xv[m_owner];
                inr = (xv[m_owner] < 6) && (yv[m_owner] < 6);
                a   = av[m_owner];
                w   = wv[m_owner];
                checks++; if (bus.ram_data !== 3'(dv[m_owner])) begin errors++; $display("FAIL rnd_data c=%0d: got %0d expected %0d", c, bus.ram_data, dv[m_owner]); end
            end
            checks++; if (bus.ram_addr !== 6'(ad)) begin errors++; $display("FAIL rnd_addr c=%0d: got %0d expected %0d", c, bus.ram_addr, ad); end
            checks++; if (bus.ram_wren !== (a & w & inr)) begin errors++; $display("FAIL rnd_wren c=%0d: got %b expected %b", c, bus.ram_wren, a & w & inr); end
            exp_rvalid = a & ~w & inr;
            exp_err    = a & ~inr;
            if (exp_rvalid) begin exp_rid = m_owner; exp_rdata = mmem[ad]; end
            if (a & w & inr) mmem[ad] = 3'(dv[m_owner]);
            if (m_owner < 0 || !r[m_owner]) begin
                nw = pick(r);
                if (nw >= 0) m_rr_start = (nw + 1) % 3;
                m_owner = nw;
            end
            exp_grant = (m_owner < 0) ? 3'b000 : 3'(1 << m_owner);
            tick();
        end
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_handoff();
        test_read();
        test_write_read();
        test_out_of_range();
        test_back_to_back();
        test_policy();
        test_reset_midread();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete within the time limit");
        $fatal(1, "timeout");
    end
endmodule
